pipe_skid_buffer: RTL
=====================

# pipe_skid_buffer

Two-entry valid/ready pipeline register slice with fully registered outputs. It breaks combinational paths on both the forward path (valid/data) and the backward path (ready) between a producer and a consumer, and sustains one transfer per cycle. It is the stage the team places in front of plain data flops wherever a stream carries backpressure. Data registers use the same parameterised width and reset value as the team's existing flops.

## Interface
- WDT, 8: payload width in bits.
- RESET_VAL, 0: reset value of both payload registers and therefore of out_data.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all stored entries.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  stage can accept a word; registered.
- in_data  input  WDT  producer payload.
- out_valid  output  1  out_data holds a valid word; registered.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WDT  payload; driven directly from the main register.
- level  output  2  occupancy, 0..2.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Storage: a main register drives out_data, and a skid register catches a word that arrives while the consumer stalls.
- States:
  - EMPTY (level 0): out_valid=0, in_ready=1.
  - BUSY (level 1): out_valid=1, in_ready=1.
  - FULL (level 2): out_valid=1, in_ready=0.
- Transitions in EMPTY:
  - in_valid -> BUSY; main <= in_data.
  - Otherwise stay in EMPTY.
- Transitions in BUSY:
  - in_valid & out_ready -> BUSY; main <= in_data.
  - in_valid & !out_ready -> FULL; skid <= in_data; main holds.
  - !in_valid & out_ready -> EMPTY.
  - Otherwise hold.
- Transitions in FULL:
  - out_ready -> BUSY; main <= skid.
  - Otherwise hold. in_valid is ignored because in_ready=0.
- flush has priority over every transfer:
  - Next state is EMPTY.
  - Any input or output handshake in the flush cycle is discarded and not stored.
  - Payload registers are not cleared by flush.
- Ordering is strict FIFO. No word is ever dropped or duplicated outside flush.
- The stage places no constraint on the producer's in_valid: it may deassert without a transfer occurring.

## Timing
- During and after reset: state EMPTY, out_valid=0, in_ready=1, level=0, out_data=RESET_VAL, skid=RESET_VAL.
- Latency: a word accepted at edge N is on out_data with out_valid=1 after edge N, i.e. it is visible in cycle N+1.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Backpressure: in_ready falls one cycle after the first stalled cycle in BUSY that also accepts an input.
- in_ready rises the cycle after the FULL->BUSY drain.
- The skid entry absorbs the single word accepted in the cycle before in_ready drops.
- in_ready, out_valid, out_data and level are pure register outputs, with no combinational path from any input.
- Reset asserted mid-stream returns the stage to EMPTY asynchronously. Stored words are lost.
- flush and reset produce identical control state; they differ only in that flush leaves the payload registers unchanged.

## Structure
- Package pipe_pkg holds:
  - typedef enum logic [1:0] skid_state_t {EMPTY, BUSY, FULL}.
  - Constant LEVEL_W = 2.
- Sub-module: d_flip_flop with WDT and RESET_VAL, instantiated twice for the main and skid payload registers.
- Each payload register's d_in is a mux that holds its current value when no load is required.
- The state machine and its next-state/load-enable logic live in pipe_skid_buffer.

## Test plan
- **Reset:** assert rst_n=0 mid-cycle with RESET_VAL=8'hA5 -> out_valid=0, in_ready=1, level=0, out_data=8'hA5 immediately, without waiting for a clock edge.
- **Streaming:** in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data=1,2,3,4 starting one cycle later; level stays 1; in_ready never drops.
- **Stall:**
  - Stimulus: send 10 then 11, out_ready=0 throughout.
  - Required response: level=2 and in_ready=0 after the second accept; 12 is held off by the producer.
  - Then raise out_ready -> 10, 11, 12 delivered in order; no loss.
- **Simultaneous events in BUSY:** in_valid & out_ready in the same cycle -> level stays 1 and the new word replaces the delivered one on out_data.
- **Flush in FULL with in_valid=1:** -> next cycle level=0, out_valid=0, in_ready=1; the word offered during flush is never output.
- **Random scoreboard:** random in_valid/out_ready, 10k cycles -> output sequence equals input sequence, and no cycle shows in_ready=0 in any state other than FULL.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready skid buffer stage.
package pipe_pkg;

    localparam int LEVEL_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Occupancy reported for each state.
    function automatic logic [LEVEL_W-1:0] state_level(input skid_state_t s);
        case (s)
            BUSY:    state_level = LEVEL_W'(1);
            FULL:    state_level = LEVEL_W'(2);
            default: state_level = LEVEL_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/d_flip_flop.sv
// Parameterised payload register with asynchronous active-low reset.
module d_flip_flop #(
    parameter int             WDT       = 8,
    parameter logic [WDT-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WDT-1:0] d_in,
    output logic [WDT-1:0] q
);

    // Capture d_in every cycle; the caller supplies a hold mux on d_in.
    // NOTE: payload is reset here because out_data must show RESET_VAL straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            q <= d_in;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready register slice: registered valid, ready and data,
// one transfer per cycle, strict FIFO order, synchronous flush.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int             WDT       = 8,
    parameter logic [WDT-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WDT-1:0]     in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WDT-1:0]     out_data,
    output logic [LEVEL_W-1:0] level
);

    skid_state_t        state, state_nxt;
    logic               load_main, load_skid, main_from_skid;
    logic [WDT-1:0]     main_q, skid_q;
    logic [WDT-1:0]     main_d, skid_d;
    logic               out_valid_q, in_ready_q;
    logic [LEVEL_W-1:0] level_q;

    // Next-state and payload load enables; flush overrides every handshake.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        state_nxt = BUSY;
                        load_main = 1'b1;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        load_main = 1'b1;
                    end else if (in_valid) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (out_ready) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so in_valid is not a transfer.
                    if (out_ready) begin
                        state_nxt      = BUSY;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State register plus status flops decoded from the next state, so the
    // status outputs leave the block straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            level_q     <= '0;
        end else begin
            state       <= state_nxt;
            out_valid_q <= (state_nxt != EMPTY);
            in_ready_q  <= (state_nxt != FULL);
            level_q     <= state_level(state_nxt);
        end
    end

    // Payload muxes: load the selected source or hold the current word.
    assign main_d = load_main ? (main_from_skid ? skid_q : in_data) : main_q;
    assign skid_d = load_skid ? in_data : skid_q;

    d_flip_flop #(.WDT(WDT), .RESET_VAL(RESET_VAL)) u_main_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (main_d),
        .q     (main_q)
    );

    d_flip_flop #(.WDT(WDT), .RESET_VAL(RESET_VAL)) u_skid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (skid_d),
        .q     (skid_q)
    );

    assign out_data  = main_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign level     = level_q;

endmodule
